// File: rtl/jam_pkg.sv
// Shared types for the job-assignment engine: FSM states, permutation storage
// and width helpers.
package jam_pkg;
  localparam int MAX_N  = 10;
  localparam int PIDX_W = 4;

  typedef enum logic [2:0] {LOAD, FETCH, CMP, NEXT, DONE} state_t;

  typedef logic [PIDX_W-1:0] pidx_t;
  // Sized for the largest legal N; entries at N and above stay unused.
  typedef pidx_t perm_t [MAX_N];

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int sum_w(input int cost_w, input int n);
    return cost_w + $clog2(n);
  endfunction
endpackage

// File: rtl/jam_param_if.sv
// Cost ROM port: the engine drives the worker/job address and the ROM
// returns the cost combinationally in the same cycle.
interface jam_param_if #(
  parameter int IDX_W  = 3,
  parameter int COST_W = 7
);
  logic [IDX_W-1:0]  W;
  logic [IDX_W-1:0]  J;
  logic [COST_W-1:0] Cost;

  modport master (output W, output J, input Cost);
  modport slave  (input W, input J, output Cost);
endinterface

// File: rtl/jam_perm_next.sv
// Single-cycle lexicographic successor of the first N permutation entries.
// The last flag is set when no pivot exists.
module jam_perm_next import jam_pkg::*; #(
  parameter int N = 8
) (
  input  perm_t perm,
  output perm_t perm_nxt,
  output logic  last
);
  int    p, s;
  logic  found;
  perm_t sw;

  always_comb begin
    found = 1'b0;
    p     = 0;
    s     = 0;
    for (int k = 0; k < N - 1; k++)
      if (perm[k] < perm[k+1]) begin
        found = 1'b1;
        p     = k;
      end
    for (int k = 0; k < N; k++)
      if (k > p && perm[k] > perm[p]) s = k;

    sw    = perm;
    sw[p] = perm[s];
    sw[s] = perm[p];

    // Tail after the pivot is descending; reversing it makes it ascending.
    perm_nxt = sw;
    for (int k = 0; k < N; k++)
      if (k > p) perm_nxt[k] = sw[N + p - k];

    last = !found;
  end
endmodule

// File: rtl/jam_param.sv
// Exhaustive job-assignment engine: walks all N! permutations in lexicographic
// order, sums costs fetched from an external ROM, tracks minimum and ties.
module jam_param import jam_pkg::*; #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int IDX_W  = idx_w(N),
  parameter int SUM_W  = sum_w(COST_W, N),
  parameter int CNT_W  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  jam_param_if.master      rom,
  output logic [CNT_W-1:0] MatchCount,
  output logic [SUM_W-1:0] MinCost,
  output logic [N*IDX_W-1:0] MinPerm,
  output logic             Valid
);
  state_t               state, state_nxt;
  perm_t                perm, perm_nxt;
  logic                 last;
  logic [SUM_W-1:0]     acc;
  logic [IDX_W-1:0]     i;
  logic [N*IDX_W-1:0]   perm_flat;

  jam_perm_next #(.N(N)) u_next (
    .perm     (perm),
    .perm_nxt (perm_nxt),
    .last     (last)
  );

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign perm_flat[k*IDX_W +: IDX_W] = perm[k][IDX_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    state_nxt = FETCH;
      FETCH:   if (i == IDX_W'(N - 1)) state_nxt = CMP;
      CMP:     state_nxt = NEXT;
      NEXT:    state_nxt = last ? DONE : FETCH;
      DONE:    state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  // Address is gated to zero outside FETCH so the ROM never sees i == N.
  always_comb begin
    rom.W = '0;
    rom.J = '0;
    if (state == FETCH) begin
      rom.W = i;
      rom.J = perm[PIDX_W'(i)][IDX_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc        <= '0;
      i          <= '0;
      Valid      <= 1'b0;
      MinCost    <= '1;
      MatchCount <= '0;
      MinPerm    <= '0;
      for (int k = 0; k < MAX_N; k++) perm[k] <= PIDX_W'(k);
    end else begin
      Valid <= 1'b0;
      unique case (state)
        LOAD: begin
          for (int k = 0; k < MAX_N; k++) perm[k] <= PIDX_W'(k);
          acc <= '0;
          i   <= '0;
        end
        FETCH: begin
          acc <= acc + SUM_W'(rom.Cost);
          i   <= i + 1'b1;
        end
        CMP: begin
          if (acc < MinCost) begin
            MinCost    <= acc;
            MatchCount <= CNT_W'(1);
            MinPerm    <= perm_flat;
          end else if (acc == MinCost && MatchCount != '1) begin
            MatchCount <= MatchCount + 1'b1;
          end
        end
        NEXT: begin
          acc <= '0;
          i   <= '0;
          if (last) Valid <= 1'b1;
          else      perm  <= perm_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jam_param.sv
// Scoreboard bench for jam_param at N=5: a brute-force model enumerates all
// index tuples in order, and a monitor checks results whenever Valid fires.
module tb_jam_param;
  localparam int N      = 5;
  localparam int COST_W = 7;
  localparam int IDX_W  = $clog2(N);
  localparam int SUM_W  = COST_W + $clog2(N);
  localparam int CNT_W  = 4;

  typedef struct {
    int                 minc;
    int                 cnt;
    logic [N*IDX_W-1:0] perm;
    int                 lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNT_W-1:0]   match_count;
  logic [SUM_W-1:0]   min_cost;
  logic [N*IDX_W-1:0] min_perm;
  logic               valid;

  logic [COST_W-1:0] cost [N][N];
  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0, failures = 0;
  int   done_cnt = 0, oob = 0, cyc = 0;
  bit   hold_pending = 0;

  jam_param_if #(.IDX_W(IDX_W), .COST_W(COST_W)) bus ();
  assign bus.Cost = (bus.W < N && bus.J < N) ? cost[bus.W][bus.J] : '0;

  jam_param #(.N(N), .COST_W(COST_W), .CNT_W(CNT_W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .rom        (bus),
    .MatchCount (match_count),
    .MinCost    (min_cost),
    .MinPerm    (min_perm),
    .Valid      (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Brute force: every N-digit base-N tuple in increasing order is
  // lexicographic order; non-permutations are skipped.
  function automatic exp_t model();
    exp_t e;
    int best, cnt, tot, fact, r, sum;
    int d [N];
    bit used [N];
    bit ok;
    best = 1 << 30; cnt = 0; tot = 1; fact = 1;
    e.perm = '0;
    for (int k = 0; k < N; k++) begin tot *= N; fact *= (k + 1); end
    for (int idx = 0; idx < tot; idx++) begin
      r = idx; ok = 1; sum = 0;
      for (int k = N - 1; k >= 0; k--) begin d[k] = r % N; r = r / N; end
      for (int k = 0; k < N; k++) used[k] = 0;
      for (int k = 0; k < N; k++) begin
        if (used[d[k]]) ok = 0;
        used[d[k]] = 1;
      end
      if (ok) begin
        for (int k = 0; k < N; k++) sum += int'(cost[k][d[k]]);
        if (sum < best) begin
          best = sum; cnt = 1;
          for (int k = 0; k < N; k++) e.perm[k*IDX_W +: IDX_W] = IDX_W'(d[k]);
        end else if (sum == best && cnt < 15) begin
          cnt++;
        end
      end
    end
    e.minc = best;
    e.cnt  = cnt;
    e.lat  = 1 + fact * (N + 2);
    return e;
  endfunction

  // Monitor: address range every cycle, full result on Valid, hold after it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.W >= N || bus.J >= N)) oob++;
    if (hold_pending) begin
      hold_pending = 0;
      chk("valid_one_cycle", valid, 0);
      chk("mincost_hold", min_cost, last_exp.minc);
      chk("minperm_hold", min_perm, last_exp.perm);
    end
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("latency", cyc, e.lat);
        chk("mincost", min_cost, e.minc);
        chk("matchcount", match_count, e.cnt);
        chk("minperm", min_perm, e.perm);
        chk("wj_range", oob, 0);
        last_exp = e;
        hold_pending = 1;
      end
      oob = 0;
      done_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_W", bus.W, 0);
    chk("rst_J", bus.J, 0);
    chk("rst_valid", valid, 0);
    chk("rst_mincost", min_cost, (1 << SUM_W) - 1);
    chk("rst_matchcount", match_count, 0);
    chk("rst_minperm", min_perm, 0);
    rst = 1'b0;
    oob = 0;
  endtask

  task automatic run(input bit mid_reset);
    int prev, t;
    prev = done_cnt;
    exp_q.push_back(model());
    do_reset();
    if (mid_reset) begin
      repeat (52) @(posedge clk);
      #1;
      do_reset();
    end
    t = 0;
    while (done_cnt == prev && t < 3000) begin @(posedge clk); t++; end
    chk("valid_seen", done_cnt != prev, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    // Constant row/column structure: every permutation sums alike.
    for (int w = 0; w < N; w++) for (int j = 0; j < N; j++) cost[w][j] = COST_W'(3*w + j);
    run(0);
    // Anti-diagonal is the unique zero-cost assignment.
    for (int w = 0; w < N; w++) for (int j = 0; j < N; j++) cost[w][j] = (j == N-1-w) ? 0 : 5;
    run(0);
    for (int w = 0; w < N; w++) for (int j = 0; j < N; j++) cost[w][j] = 0;
    run(0);
    for (int w = 0; w < N; w++) for (int j = 0; j < N; j++) cost[w][j] = 127;
    run(0);
    for (int w = 0; w < N; w++) for (int j = 0; j < N; j++) cost[w][j] = (w == j) ? 0 : 1;
    run(0);
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < N; w++) for (int j = 0; j < N; j++)
        cost[w][j] = COST_W'((r < 3) ? $urandom_range(0, 127) : $urandom_range(0, 3));
      run(0);
    end
    // Abort mid-run, restart must reproduce the anti-diagonal result exactly.
    for (int w = 0; w < N; w++) for (int j = 0; j < N; j++) cost[w][j] = (j == N-1-w) ? 0 : 5;
    run(1);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
